// File: rtl/priority_encode_pipe.sv
// Pipelined lowest/highest-set-bit encoder with per-request mode, residual output and
// valid/ready backpressure. Tree levels are grouped LEVELS_PER_STAGE per register stage.
module priority_encode_pipe #(
    parameter int WIDTH            = 32,
    parameter int LOG_WIDTH        = 5,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_WIDTH        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_decode,
    input  logic                 in_msb_first,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_found,
    output logic [LOG_WIDTH-1:0] out_index,
    output logic [WIDTH-1:0]     out_residual,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int N    = 1 << LOG_WIDTH;
    localparam int LPS  = LEVELS_PER_STAGE;
    localparam int LAT  = (LOG_WIDTH + LPS - 1) / LPS;
    localparam int NREG = (LAT > 1) ? LAT - 1 : 1;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("priority_encode_pipe: WIDTH must be at least 2");
        end
        if (N < WIDTH) begin : g_bad_log_width
            $error("priority_encode_pipe: 2**LOG_WIDTH must be >= WIDTH");
        end
        if (LPS < 1 || LPS > LOG_WIDTH) begin : g_bad_lps
            $error("priority_encode_pipe: LEVELS_PER_STAGE must be in 1..LOG_WIDTH");
        end
    endgenerate

    typedef logic [LOG_WIDTH-1:0] idx_t;

    // Node j after L merged levels covers bits [j*2**L +: 2**L]; idx holds the low L bits.
    typedef struct packed {
        logic [N-1:0]                any;
        logic [N-1:0][LOG_WIDTH-1:0] idx;
    } tree_t;

    typedef struct packed {
        tree_t                tree;
        logic                 msb;
        logic [WIDTH-1:0]     vec;
        logic [TAG_WIDTH-1:0] tag;
    } stage_t;

    function automatic tree_t leaves(input logic [WIDTH-1:0] vec);
        tree_t t;
        t     = '0;
        t.any = N'(vec);
        return t;
    endfunction

    function automatic tree_t merge_level(input tree_t t, input int lvl, input logic msb);
        tree_t r;
        logic  alo;
        logic  ahi;
        logic  sel_hi;
        r = '0;
        for (int j = 0; j < N / 2; j++) begin
            if (j < (N >> (lvl + 1))) begin
                alo      = t.any[2*j];
                ahi      = t.any[2*j+1];
                // An empty pair never selects the upper half, so not-found yields index 0.
                sel_hi   = msb ? ahi : (ahi & ~alo);
                r.any[j] = alo | ahi;
                r.idx[j] = sel_hi ? (t.idx[2*j+1] | (idx_t'(1) << lvl)) : t.idx[2*j];
            end
        end
        return r;
    endfunction

    function automatic stage_t apply_levels(input stage_t s, input int first, input int last);
        stage_t r;
        r = s;
        for (int l = 0; l < LOG_WIDTH; l++) begin
            if (l >= first && l < last) begin
                r.tree = merge_level(r.tree, l, r.msb);
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] clear_winner(input logic [WIDTH-1:0] vec,
                                                      input logic found, input idx_t idx);
        logic [WIDTH-1:0] r;
        r = vec;
        for (int i = 0; i < WIDTH; i++) begin
            if (found && idx == idx_t'(i)) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_d;
    logic [LAT-1:0] adv;
    logic [LAT-1:0] load;

    // Advance chain runs from the output back to the input; in_valid never feeds it.
    always_comb begin
        adv        = '0;
        adv[LAT-1] = !vld_q[LAT-1] || out_ready;
        for (int k = LAT - 2; k >= 0; k--) begin
            adv[k] = !vld_q[k] || adv[k+1];
        end
    end

    always_comb begin
        vld_d   = vld_q;
        load    = '0;
        load[0] = adv[0] && in_valid;
        if (adv[0]) begin
            vld_d[0] = in_valid;
        end
        for (int k = 1; k < LAT; k++) begin
            load[k] = adv[k] && vld_q[k-1];
            if (adv[k]) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[LAT-1];

    stage_t stg_q [NREG];
    stage_t src   [LAT];
    stage_t nxt   [LAT];

    generate
        for (genvar k = 0; k < LAT; k++) begin : g_stage
            localparam int FIRST = k * LPS;
            localparam int LAST  = ((k + 1) * LPS > LOG_WIDTH) ? LOG_WIDTH : (k + 1) * LPS;

            if (k == 0) begin : g_src_in
                assign src[k] = {leaves(in_decode), in_msb_first, in_decode, in_tag};
            end else begin : g_src_reg
                assign src[k] = stg_q[k-1];
            end

            assign nxt[k] = apply_levels(src[k], FIRST, LAST);

            if (k < LAT - 1) begin : g_payload
                // Payload registers are not reset; their valid bit qualifies them.
                always_ff @(posedge clk) begin
                    if (load[k]) begin
                        stg_q[k] <= nxt[k];
                    end
                end
            end
        end
    endgenerate

    logic                 out_found_q;
    idx_t                 out_index_q;
    logic [WIDTH-1:0]     out_residual_q;
    logic [TAG_WIDTH-1:0] out_tag_q;

    // Output stage: final tree level plus winner clearing, reset so outputs idle at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_found_q    <= 1'b0;
            out_index_q    <= '0;
            out_residual_q <= '0;
            out_tag_q      <= '0;
        end else if (load[LAT-1]) begin
            out_found_q    <= nxt[LAT-1].tree.any[0];
            out_index_q    <= nxt[LAT-1].tree.idx[0];
            out_residual_q <= clear_winner(nxt[LAT-1].vec, nxt[LAT-1].tree.any[0],
                                           nxt[LAT-1].tree.idx[0]);
            out_tag_q      <= nxt[LAT-1].tag;
        end
    end

    assign out_found    = out_found_q;
    assign out_index    = out_index_q;
    assign out_residual = out_residual_q;
    assign out_tag      = out_tag_q;

endmodule

// File: tb/tb_priority_encode_pipe.sv
// Directed bench for priority_encode_pipe: default 32-bit instance (LAT=3) and a
// 20-bit instance with one level per stage (LAT=5).
module tb_priority_encode_pipe;

    localparam int LAT_A = 3;
    localparam int LAT_B = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_in_ready, a_in_msb = 1'b0;
    logic        a_out_valid, a_out_ready = 1'b1, a_out_found;
    logic [31:0] a_in_decode = '0, a_out_residual;
    logic [7:0]  a_in_tag = '0, a_out_tag;
    logic [4:0]  a_out_index;

    logic        b_in_valid = 1'b0, b_in_ready, b_in_msb = 1'b0;
    logic        b_out_valid, b_out_ready = 1'b1, b_out_found;
    logic [19:0] b_in_decode = '0, b_out_residual;
    logic [7:0]  b_in_tag = '0, b_out_tag;
    logic [4:0]  b_out_index;

    int checks   = 0;
    int failures = 0;

    priority_encode_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_decode(a_in_decode),
        .in_msb_first(a_in_msb), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_found(a_out_found),
        .out_index(a_out_index), .out_residual(a_out_residual), .out_tag(a_out_tag)
    );

    priority_encode_pipe #(.WIDTH(20), .LOG_WIDTH(5), .LEVELS_PER_STAGE(1), .TAG_WIDTH(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_decode(b_in_decode),
        .in_msb_first(b_in_msb), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_found(b_out_found),
        .out_index(b_out_index), .out_residual(b_out_residual), .out_tag(b_out_tag)
    );

    // Present one request to the idle 32-bit instance and capture its result LAT_A edges later.
    task automatic run_a(input logic [31:0] vec, input logic msb, input logic [7:0] tag,
                         output logic early, output logic ov, output logic fnd,
                         output logic [4:0] idx, output logic [31:0] res, output logic [7:0] tg);
        early = 1'b0;
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_decode = vec;
        a_in_msb    = msb;
        a_in_tag    = tag;
        for (int i = 1; i <= LAT_A; i++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b0;
            if (i < LAT_A) early = early | a_out_valid;
        end
        ov  = a_out_valid;
        fnd = a_out_found;
        idx = a_out_index;
        res = a_out_residual;
        tg  = a_out_tag;
    endtask

    task automatic run_b(input logic [19:0] vec, input logic msb, input logic [7:0] tag,
                         output logic early, output logic ov, output logic fnd,
                         output logic [4:0] idx, output logic [19:0] res, output logic [7:0] tg);
        early = 1'b0;
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_decode = vec;
        b_in_msb    = msb;
        b_in_tag    = tag;
        for (int i = 1; i <= LAT_B; i++) begin
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            if (i < LAT_B) early = early | b_out_valid;
        end
        ov  = b_out_valid;
        fnd = b_out_found;
        idx = b_out_index;
        res = b_out_residual;
        tg  = b_out_tag;
    endtask

    task automatic test_reset;
        logic [46:0] obs;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {a_out_valid, a_out_found, a_out_index, a_out_residual, a_out_tag};
        checks++;
        if (obs !== 47'h0) begin
            failures++;
            $display("FAIL reset_outputs_a: got %h expected 0", obs);
        end
        checks++;
        if ({b_out_valid, b_out_found, b_out_index, b_out_residual, b_out_tag} !== 35'h0) begin
            failures++;
            $display("FAIL reset_outputs_b: got %h expected 0",
                     {b_out_valid, b_out_found, b_out_index, b_out_residual, b_out_tag});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({a_in_ready, b_in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 11", {a_in_ready, b_in_ready});
        end
    endtask

    task automatic test_lsb;
        logic e, v, f;
        logic [4:0] i;
        logic [31:0] r;
        logic [7:0] t;
        run_a(32'h0000_0A00, 1'b0, 8'h11, e, v, f, i, r, t);
        checks++;
        if ({e, v} !== 2'b01) begin
            failures++;
            $display("FAIL lsb_latency: early/valid got %b expected 01", {e, v});
        end
        checks++;
        if ({f, i, r, t} !== {1'b1, 5'd9, 32'h0000_0800, 8'h11}) begin
            failures++;
            $display("FAIL lsb_result: got found=%b idx=%0d res=%h tag=%h expected 1 9 00000800 11",
                     f, i, r, t);
        end
    endtask

    task automatic test_msb;
        logic e, v, f;
        logic [4:0] i;
        logic [31:0] r;
        logic [7:0] t;
        run_a(32'h0000_0A00, 1'b1, 8'h22, e, v, f, i, r, t);
        checks++;
        if ({e, v, f, i, r, t} !== {2'b01, 1'b1, 5'd11, 32'h0000_0200, 8'h22}) begin
            failures++;
            $display("FAIL msb_a00: got v=%b f=%b idx=%0d res=%h tag=%h expected 1 1 11 00000200 22",
                     v, f, i, r, t);
        end
        run_a(32'h8000_0001, 1'b1, 8'h33, e, v, f, i, r, t);
        checks++;
        if ({e, v, f, i, r, t} !== {2'b01, 1'b1, 5'd31, 32'h0000_0001, 8'h33}) begin
            failures++;
            $display("FAIL msb_ends: got v=%b f=%b idx=%0d res=%h tag=%h expected 1 1 31 00000001 33",
                     v, f, i, r, t);
        end
        run_a(32'h8000_0001, 1'b0, 8'h44, e, v, f, i, r, t);
        checks++;
        if ({e, v, f, i, r, t} !== {2'b01, 1'b1, 5'd0, 32'h8000_0000, 8'h44}) begin
            failures++;
            $display("FAIL lsb_ends: got v=%b f=%b idx=%0d res=%h tag=%h expected 1 1 0 80000000 44",
                     v, f, i, r, t);
        end
    endtask

    task automatic test_back_to_back;
        int r;
        logic [46:0] obs;
        logic [46:0] exp;
        for (int m = 0; m < 33 + LAT_A; m++) begin
            @(posedge clk); #1;
            a_out_ready = 1'b1;
            if (m >= LAT_A) begin
                r   = m - LAT_A;
                exp = (r < 32) ? {1'b1, 1'b1, 5'(r), 32'h0, 8'(r)}
                               : {1'b1, 1'b0, 5'd0, 32'h0, 8'hEE};
                obs = {a_out_valid, a_out_found, a_out_index, a_out_residual, a_out_tag};
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL b2b_result_%0d: got %h expected %h", r, obs, exp);
                end
            end
            if (m < 33) begin
                checks++;
                if (a_in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready_%0d: got %b expected 1", m, a_in_ready);
                end
                a_in_valid  = 1'b1;
                a_in_decode = (m < 32) ? (32'h1 << m) : 32'h0;
                a_in_msb    = m[0];
                a_in_tag    = (m < 32) ? 8'(m) : 8'hEE;
            end else begin
                a_in_valid = 1'b0;
            end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int got  = 0;
        logic [46:0] obs;
        for (int m = 0; m < 40 && got < 5; m++) begin
            @(posedge clk); #1;
            a_out_ready = (m >= 6);
            #1;
            if (m >= 3 && m <= 5) begin
                checks++;
                if (a_in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready_low_%0d: got %b expected 0", m, a_in_ready);
                end
                obs = {a_out_valid, a_out_found, a_out_index, a_out_residual, a_out_tag};
                checks++;
                if (obs !== {1'b1, 1'b1, 5'd3, 32'h0010_0000, 8'hA0}) begin
                    failures++;
                    $display("FAIL bp_hold_%0d: got %h expected %h", m, obs,
                             {1'b1, 1'b1, 5'd3, 32'h0010_0000, 8'hA0});
                end
            end
            if (a_out_valid && a_out_ready) begin
                checks++;
                if ({a_out_found, a_out_index, a_out_residual, a_out_tag} !==
                    {1'b1, 5'(3 + got), 32'h0010_0000, 8'(8'hA0 + got)}) begin
                    failures++;
                    $display("FAIL bp_result_%0d: got f=%b idx=%0d res=%h tag=%h expected 1 %0d 00100000 %h",
                             got, a_out_found, a_out_index, a_out_residual, a_out_tag, 3 + got,
                             8'(8'hA0 + got));
                end
                got++;
            end
            if (sent < 5) begin
                a_in_valid  = 1'b1;
                a_in_decode = (32'h1 << (3 + sent)) | 32'h0010_0000;
                a_in_msb    = 1'b0;
                a_in_tag    = 8'(8'hA0 + sent);
                if (a_in_ready) sent++;
            end else begin
                a_in_valid = 1'b0;
            end
            if (m == 5) begin
                checks++;
                if (sent != 3) begin
                    failures++;
                    $display("FAIL bp_accepted_while_stalled: got %0d expected 3", sent);
                end
            end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        checks++;
        if (got != 5 || sent != 5) begin
            failures++;
            $display("FAIL bp_all_delivered: got sent=%0d out=%0d expected 5 5", sent, got);
        end
    endtask

    task automatic test_extract;
        logic e, v, f;
        logic [4:0] i;
        logic [31:0] r;
        logic [7:0] t;
        logic [31:0] vec = 32'h0000_00F0;
        logic [31:0] ex_res [5] = '{32'hE0, 32'hC0, 32'h80, 32'h00, 32'h00};
        logic [4:0]  ex_idx [5] = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd0};
        logic        ex_fnd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            run_a(vec, 1'b0, 8'(k), e, v, f, i, r, t);
            checks++;
            if ({e, v, f, i, r} !== {2'b01, ex_fnd[k], ex_idx[k], ex_res[k]}) begin
                failures++;
                $display("FAIL extract_%0d: got v=%b f=%b idx=%0d res=%h expected 1 %b %0d %h",
                         k, v, f, i, r, ex_fnd[k], ex_idx[k], ex_res[k]);
            end
            vec = r;
        end
    endtask

    task automatic test_mid_reset;
        int stale = 0;
        logic [46:0] obs;
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_decode = 32'h0000_00F0;
        a_in_msb    = 1'b0;
        a_in_tag    = 8'h55;
        @(posedge clk); #1;
        a_in_decode = 32'h0000_0003;
        a_in_msb    = 1'b1;
        a_in_tag    = 8'h66;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        obs = {a_out_valid, a_out_found, a_out_index, a_out_residual, a_out_tag};
        checks++;
        if (obs !== {1'b1, 1'b1, 5'd4, 32'h0000_00E0, 8'h55}) begin
            failures++;
            $display("FAIL rst_pre_result: got %h expected %h", obs,
                     {1'b1, 1'b1, 5'd4, 32'h0000_00E0, 8'h55});
        end
        rst_n = 1'b0;
        #1;
        obs = {a_out_valid, a_out_found, a_out_index, a_out_residual, a_out_tag};
        checks++;
        if (obs !== 47'h0) begin
            failures++;
            $display("FAIL rst_mid_clear: got %h expected 0", obs);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (a_out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL rst_no_stale: got %0d valid cycles expected 0", stale);
        end
        checks++;
        if (a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_ready: got %b expected 1", a_in_ready);
        end
    endtask

    task automatic test_width20;
        logic e, v, f;
        logic [4:0] i;
        logic [19:0] r;
        logic [7:0] t;
        logic [19:0] vecs [5] = '{20'hF_FFFF, 20'hF_FFFF, 20'h8_0000, 20'h0_0000, 20'h0_0401};
        logic        msbs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        ex_f [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0]  ex_i [5] = '{5'd19, 5'd0, 5'd19, 5'd0, 5'd10};
        logic [19:0] ex_r [5] = '{20'h7_FFFF, 20'hF_FFFE, 20'h0_0000, 20'h0_0000, 20'h0_0001};
        for (int k = 0; k < 5; k++) begin
            run_b(vecs[k], msbs[k], 8'(8'h20 + k), e, v, f, i, r, t);
            checks++;
            if ({e, v, f, i, r, t} !== {2'b01, ex_f[k], ex_i[k], ex_r[k], 8'(8'h20 + k)}) begin
                failures++;
                $display("FAIL w20_case_%0d: got early=%b v=%b f=%b idx=%0d res=%h tag=%h expected 0 1 %b %0d %h %h",
                         k, e, v, f, i, r, t, ex_f[k], ex_i[k], ex_r[k], 8'(8'h20 + k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb();
        test_msb();
        test_back_to_back();
        test_backpressure();
        test_extract();
        test_mid_reset();
        test_width20();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
